ps2_kbd_rx: RTL
===============

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FREQ_HZ, default 12000000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, giving the maximum gap in microseconds between PS/2 clock falling edges within one frame.
REQ-003 SHALL have parameter FILTER_CYCLES, default 8, giving the number of consecutive stable clk cycles required to accept a PS/2 clock level change.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1, synchronous active-low reset.
REQ-006 SHALL have port ps2_clk_i, input, 1, asynchronous PS/2 clock line from the device (idle high).
REQ-007 SHALL have port ps2_data_i, input, 1, asynchronous PS/2 data line from the device (idle high).
REQ-008 SHALL have port code_o, output, 8, the last correctly received scan-code byte.
REQ-009 SHALL have port strobe_o, output, 1, a one-cycle pulse meaning code_o was just updated.
REQ-010 SHALL have port err_o, output, 1, a one-cycle pulse meaning a frame was rejected.

Function
REQ-011 SHALL pass each PS/2 line through a 2-flop synchronizer.
REQ-012 SHALL accept a synchronized ps2_clk level change only after FILTER_CYCLES consecutive identical samples; shorter glitches are ignored.
REQ-013 SHALL define a sample event as a 1->0 transition of the filtered clock, and SHALL sample synchronized data in the cycle of that event.
REQ-014 SHALL have frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1 (11 bits total).
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE, a sample of 0 SHALL clear the bit counter and go to DATA; a sample of 1 SHALL pulse err_o and stay in IDLE.
REQ-017 In DATA, each sample SHALL shift into the MSB of an 8-bit shift register; after the 8th sample the FSM SHALL go to PARITY.
REQ-018 In PARITY, the FSM SHALL record parity_ok = XOR of the 8 data bits and the parity bit (must equal 1), then go to STOP.
REQ-019 In STOP, if the stop sample is 1 and parity_ok is set, the block SHALL load code_o from the shift register and assert strobe_o for exactly one cycle, in the cycle after the stop sample; otherwise it SHALL pulse err_o and leave code_o unchanged; both cases SHALL return to IDLE.
REQ-020 SHALL compute TIMEOUT_CYCLES = FREQ_HZ/1000000*TIMEOUT_US, using a counter of width $clog2(TIMEOUT_CYCLES+1).
REQ-021 SHALL clear the timeout counter on every sample event and hold it at 0 in IDLE.
REQ-022 In any state other than IDLE, the counter reaching TIMEOUT_CYCLES SHALL pulse err_o the next cycle and force IDLE.
REQ-023 If a sample event and a timeout occur in the same cycle, the sample event SHALL win: the counter clears and no error is raised.
REQ-024 strobe_o and err_o SHALL never be asserted in the same cycle.
REQ-025 code_o SHALL hold its value between strobes.
REQ-026 The block SHALL NOT drive the PS/2 lines; it is receive-only.

Reset
REQ-027 While reset_ni=0 at a clk edge: state SHALL be IDLE; code_o, strobe_o, err_o, the shift register, bit counter and timeout counter SHALL be 0; synchronizer and filter registers SHALL be 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no strobe_o and no err_o pulse.
REQ-029 Releasing reset while ps2_clk_i is high SHALL produce no sample event.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the state enum type and the constants DATA_BITS=8 and FRAME_BITS=11.
REQ-031 Sub-module ps2_sync_filter (synchronizer plus stability filter, parameter FILTER_CYCLES) SHALL be instantiated for ps2_clk_i; ps2_data_i SHALL use the synchronizer only.

Verification
(Bench: FREQ_HZ=12000000, PS/2 bit period 60 us = 720 cycles, data changes at mid-high clock.)
REQ-032 Frame 0x1C with parity bit 0 and stop bit 1 -> a single strobe_o pulse, code_o=0x1C, err_o stays 0.
REQ-033 Frame 0xF0 with wrong parity bit 0 -> one err_o pulse, no strobe_o, code_o remains 0x1C.
REQ-034 Frame 0x5A with correct parity and stop bit 0 -> one err_o pulse, no strobe_o, FSM back in IDLE.
REQ-035 Start bit plus 4 data bits, then ps2_clk held high -> err_o exactly 24000 cycles after the last sample event; a following 0x5A frame -> strobe_o with code_o=0x5A.
REQ-036 3-cycle low glitch on ps2_clk_i in IDLE -> no err_o, no state change; 0x29 sent mid-frame with a 3-cycle glitch on ps2_clk_i -> code_o=0x29 decoded correctly.
REQ-037 reset_ni=0 for 2 cycles after 5 data bits -> no strobe_o and no err_o; the next full frame 0x29 -> strobe_o with code_o=0x29.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared definitions.
// Frame geometry, FSM state type and parity helper.
package ps2_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Odd parity holds when data plus parity bit has an odd count of ones.
  function automatic logic odd_ok(
    input logic [DATA_BITS-1:0] d,
    input logic                 p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer plus level-stability filter.
// fall_o pulses in the cycle the filtered level is accepted as low.
module ps2_sync_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic d_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after FILTER_CYCLES differing samples in a row.
  always_comb begin
    sync0_d = d_i;
    sync1_d = sync0_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync1_q != filt_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_d = sync1_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fall_o = filt_q & ~filt_d;
  end

  // State registers; lines idle high so reset to 1.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// Receive-only PS/2 keyboard frame decoder.
// Emits each good scan code with a strobe, bad frames with err.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FREQ_HZ       = 12000000,
  parameter int TIMEOUT_US    = 2000,
  parameter int FILTER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o
);

  localparam int TIMEOUT_CYCLES = FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);

  logic                 sample_ev;
  logic                 dsync0_q, dsync0_d;
  logic                 dsync1_q, dsync1_d;
  state_e               state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_ok_q, par_ok_d;
  logic [7:0]           code_q, code_d;
  logic                 strobe_q, strobe_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  ps2_sync_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filt (
    .clk     (clk),
    .reset_ni(reset_ni),
    .d_i     (ps2_clk_i),
    .fall_o  (sample_ev)
  );

  // Frame FSM, shift register and inter-edge timeout.
  always_comb begin
    dsync0_d  = ps2_data_i;
    dsync1_d  = dsync0_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    code_d    = code_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    tmo_d     = tmo_q;

    // Counter about to reach the limit aborts the frame; a sample wins.
    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (sample_ev) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (sample_ev) begin
      unique case (state_q)
        IDLE: begin
          if (!dsync1_q) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {dsync1_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_ok_d = odd_ok(shift_q, dsync1_q);
          state_d  = STOP;
        end
        STOP: begin
          if (dsync1_q && par_ok_q) begin
            code_d   = shift_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      dsync0_q  <= 1'b1;
      dsync1_q  <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      code_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      dsync0_q  <= dsync0_d;
      dsync1_q  <= dsync1_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      code_q    <= code_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign code_o   = code_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;

endmodule
